// File: rtl/marie_core.sv
// Fetch/decode/execute sequencer for the 16-bit MARIE accumulator machine.
// Drives a single-port synchronous RAM with one-cycle read latency.
module marie_core #(
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] ac,
    output logic                  halted
);

    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUBT  = 4'h4;
    localparam logic [3:0] OP_INPUT = 4'h5;
    localparam logic [3:0] OP_OUT   = 4'h6;
    localparam logic [3:0] OP_HALT  = 4'h7;
    localparam logic [3:0] OP_SKIP  = 4'h8;
    localparam logic [3:0] OP_JUMP  = 4'h9;
    localparam logic [3:0] OP_CLEAR = 4'hA;

    localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_FWAIT,
        S_DECODE,
        S_MADDR,
        S_MWAIT,
        S_EXEC2,
        S_MWRITE,
        S_EXEC1,
        S_IN_WAIT,
        S_OUT_WAIT,
        S_HALTED
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_mar;
    logic [DATA_WIDTH-1:0] r_ir;
    logic [DATA_WIDTH-1:0] r_mbr;
    logic [DATA_WIDTH-1:0] r_ac;

    logic [3:0]            w_rd_op;
    logic [3:0]            w_ir_op;
    logic [ADDR_WIDTH-1:0] w_operand;
    logic [1:0]            w_skip_cond;
    logic                  w_ac_neg;
    logic                  w_ac_zero;
    logic                  w_skip;

    assign w_rd_op     = mem_rdata[DATA_WIDTH-1 -: 4];
    assign w_ir_op     = r_ir[DATA_WIDTH-1 -: 4];
    assign w_operand   = r_ir[ADDR_WIDTH-1:0];
    assign w_skip_cond = r_ir[ADDR_WIDTH-1 -: 2];
    assign w_ac_neg    = r_ac[DATA_WIDTH-1];
    assign w_ac_zero   = (r_ac == '0);

    // AC is compared as two's complement; condition 11 never skips.
    always_comb begin
        w_skip = 1'b0;
        case (w_skip_cond)
            2'b00:   w_skip = w_ac_neg;
            2'b01:   w_skip = w_ac_zero;
            2'b10:   w_skip = !w_ac_neg && !w_ac_zero;
            default: w_skip = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_mar   <= '0;
            r_ir    <= '0;
            r_mbr   <= '0;
            r_ac    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run) r_state <= S_FETCH;
                end
                S_FETCH: begin
                    r_mar   <= r_pc;
                    r_state <= S_FWAIT;
                end
                S_FWAIT: begin
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_ir <= mem_rdata;
                    r_pc <= r_pc + PC_ONE;
                    case (w_rd_op)
                        OP_LOAD, OP_STORE, OP_ADD, OP_SUBT: r_state <= S_MADDR;
                        OP_INPUT:                           r_state <= S_IN_WAIT;
                        OP_OUT:                             r_state <= S_OUT_WAIT;
                        OP_HALT:                            r_state <= S_HALTED;
                        default:                            r_state <= S_EXEC1;
                    endcase
                end
                S_MADDR: begin
                    r_mar <= w_operand;
                    if (w_ir_op == OP_STORE) begin
                        r_mbr   <= r_ac;
                        r_state <= S_MWRITE;
                    end else begin
                        r_state <= S_MWAIT;
                    end
                end
                S_MWAIT: begin
                    r_state <= S_EXEC2;
                end
                S_EXEC2: begin
                    r_mbr <= mem_rdata;
                    case (w_ir_op)
                        OP_LOAD: r_ac <= mem_rdata;
                        OP_ADD:  r_ac <= r_ac + mem_rdata;
                        OP_SUBT: r_ac <= r_ac - mem_rdata;
                        default: r_ac <= r_ac;
                    endcase
                    r_state <= S_FETCH;
                end
                S_MWRITE: begin
                    r_state <= S_FETCH;
                end
                S_EXEC1: begin
                    // PC already points past this instruction, so a skip adds one more.
                    case (w_ir_op)
                        OP_SKIP:  if (w_skip) r_pc <= r_pc + PC_ONE;
                        OP_JUMP:  r_pc <= w_operand;
                        OP_CLEAR: r_ac <= '0;
                        default:  r_ac <= r_ac;
                    endcase
                    r_state <= S_FETCH;
                end
                S_IN_WAIT: begin
                    if (in_valid) begin
                        r_ac    <= in_data;
                        r_state <= S_FETCH;
                    end
                end
                S_OUT_WAIT: begin
                    if (out_ready) r_state <= S_FETCH;
                end
                S_HALTED: begin
                    r_state <= S_HALTED;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes are a pure decode of the state register, so reset drops them at once.
    assign mem_cs    = (r_state == S_FWAIT) || (r_state == S_MWAIT) || (r_state == S_MWRITE);
    assign mem_oe    = (r_state == S_FWAIT) || (r_state == S_MWAIT);
    assign mem_we    = (r_state == S_MWRITE);
    assign in_ready  = (r_state == S_IN_WAIT);
    assign out_valid = (r_state == S_OUT_WAIT);
    assign halted    = (r_state == S_HALTED);

    assign mem_addr  = r_mar;
    assign mem_wdata = r_mbr;
    assign out_data  = r_ac;
    assign pc        = r_pc;
    assign ac        = r_ac;

endmodule

// File: tb/tb_marie_core.sv
// Directed self-checking bench for marie_core with a behavioural one-cycle-latency RAM.
module tb_marie_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_cs, mem_we, mem_oe;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] pc;
    logic [15:0] ac;
    logic        halted;

    logic [15:0] mem [4096];
    logic        ld_clr = 1'b0;
    logic        ld_we = 1'b0;
    logic [11:0] ld_addr = '0;
    logic [15:0] ld_data = '0;

    int errs = 0;
    int checks = 0;

    marie_core #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .RESET_PC(12'h000)) u_dut (
        .clk(clk), .rst(rst), .run(run),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .pc(pc), .ac(ac), .halted(halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_clr) begin
            for (int i = 0; i < 4096; i++) mem[i] <= '0;
        end else if (ld_we) begin
            mem[ld_addr] <= ld_data;
        end else if (mem_cs) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else if (mem_oe) mem_rdata <= mem[mem_addr];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_test();
        rst = 1'b1; run = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        ld_clr = 1'b1;
        step();
        ld_clr = 1'b0;
    endtask

    task automatic load(input logic [11:0] a, input logic [15:0] d);
        ld_addr = a; ld_data = d; ld_we = 1'b1;
        step();
        ld_we = 1'b0;
    endtask

    task automatic release_rst();
        rst = 1'b0;
        step();
    endtask

    // Counts clock edges, starting with the one that samples run in IDLE.
    task automatic wait_halt(input int max, output int n);
        n = 0;
        while (!halted && n < max) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        begin_test();
        #2;
        checks++;
        if ({mem_cs, mem_we, mem_oe, in_ready, out_valid, halted} !== 6'b0) begin
            errs++; $display("FAIL reset_strobes: got %b exp 000000", {mem_cs, mem_we, mem_oe, in_ready, out_valid, halted});
        end
        checks++;
        if (pc !== 12'h000 || ac !== 16'h0000) begin
            errs++; $display("FAIL reset_regs: pc=%h ac=%h exp 000/0000", pc, ac);
        end
        checks++;
        if (mem_addr !== 12'h000 || mem_wdata !== 16'h0000 || out_data !== 16'h0000) begin
            errs++; $display("FAIL reset_mar_mbr: addr=%h wdata=%h out=%h exp 0", mem_addr, mem_wdata, out_data);
        end
        release_rst();
        step(); step();
        checks++;
        if (mem_cs !== 1'b0 || pc !== 12'h000) begin
            errs++; $display("FAIL idle_without_run: cs=%b pc=%h exp 0/000", mem_cs, pc);
        end
    endtask

    task automatic test_load_add_store();
        int n;
        begin_test();
        load(12'h010, 16'h0005); load(12'h011, 16'h0007);
        load(12'h000, 16'h1010); load(12'h001, 16'h3011);
        load(12'h002, 16'h2012); load(12'h003, 16'h7000);
        release_rst();
        run = 1'b1;
        wait_halt(200, n);
        checks++;
        if (n !== 21 || halted !== 1'b1) begin
            errs++; $display("FAIL las_halt_latency: edges=%0d halted=%b exp 21/1", n, halted);
        end
        checks++;
        if (mem[12'h012] !== 16'h000C) begin
            errs++; $display("FAIL las_store: mem[012]=%h exp 000C", mem[12'h012]);
        end
        checks++;
        if (pc !== 12'h004 || ac !== 16'h000C) begin
            errs++; $display("FAIL las_regs: pc=%h ac=%h exp 004/000C", pc, ac);
        end
        run = 1'b0; step(); step(); run = 1'b1; step(); step(); step();
        checks++;
        if (halted !== 1'b1 || pc !== 12'h004 || mem_cs !== 1'b0) begin
            errs++; $display("FAIL halt_frozen: halted=%b pc=%h cs=%b exp 1/004/0", halted, pc, mem_cs);
        end
    endtask

    task automatic test_subt_skip();
        int n;
        begin_test();
        load(12'h010, 16'h0003);
        load(12'h000, 16'hA000); load(12'h001, 16'h4010); load(12'h002, 16'h8000);
        load(12'h003, 16'h9000); load(12'h004, 16'h7000);
        release_rst();
        run = 1'b1;
        wait_halt(200, n);
        checks++;
        if (n !== 18 || halted !== 1'b1) begin
            errs++; $display("FAIL skip_latency: edges=%0d halted=%b exp 18/1", n, halted);
        end
        checks++;
        if (ac !== 16'hFFFD || pc !== 12'h005) begin
            errs++; $display("FAIL skip_regs: ac=%h pc=%h exp FFFD/005", ac, pc);
        end
    endtask

    task automatic test_loop();
        int n;
        logic seen_out;
        begin_test();
        load(12'h020, 16'h0005); load(12'h021, 16'h0007);
        load(12'h022, 16'h0000); load(12'h023, 16'h0001);
        load(12'h000, 16'h1022); load(12'h001, 16'h3021); load(12'h002, 16'h2022);
        load(12'h003, 16'h1020); load(12'h004, 16'h4023); load(12'h005, 16'h2020);
        load(12'h006, 16'h8400); load(12'h007, 16'h9000); load(12'h008, 16'h7000);
        release_rst();
        run = 1'b1;
        n = 0; seen_out = 1'b0;
        while (!halted && n < 2000) begin
            step();
            n++;
            if (out_valid) seen_out = 1'b1;
        end
        checks++;
        if (mem[12'h022] !== 16'h0023 || mem[12'h020] !== 16'h0000) begin
            errs++; $display("FAIL loop_result: prod=%h cnt=%h exp 0023/0000", mem[12'h022], mem[12'h020]);
        end
        checks++;
        if (n !== 210 || pc !== 12'h009) begin
            errs++; $display("FAIL loop_timing: edges=%0d pc=%h exp 210/009", n, pc);
        end
        checks++;
        if (seen_out !== 1'b0) begin
            errs++; $display("FAIL loop_no_output: out_valid seen=%b exp 0", seen_out);
        end
    endtask

    task automatic test_handshake();
        int n;
        int acc;
        begin_test();
        load(12'h000, 16'h5000); load(12'h001, 16'h6000); load(12'h002, 16'h7000);
        release_rst();
        in_data = 16'h1111; in_valid = 1'b1; out_ready = 1'b1;
        step(); step();
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (ac !== 16'h0000 || pc !== 12'h000) begin
            errs++; $display("FAIL hs_ignored_idle: ac=%h pc=%h exp 0000/000", ac, pc);
        end
        run = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin step(); n++; end
        checks++;
        if (n !== 4) begin
            errs++; $display("FAIL hs_in_wait_entry: edges=%0d exp 4", n);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (in_ready !== 1'b1 || ac !== 16'h0000) begin
                errs++; $display("FAIL hs_in_stall: ready=%b ac=%h exp 1/0000", in_ready, ac);
            end
        end
        in_data = 16'hABCD; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_data = 16'h0000;
        checks++;
        if (ac !== 16'hABCD || in_ready !== 1'b0) begin
            errs++; $display("FAIL hs_in_accept: ac=%h ready=%b exp ABCD/0", ac, in_ready);
        end
        n = 0;
        while (!out_valid && n < 20) begin step(); n++; end
        checks++;
        if (n !== 3) begin
            errs++; $display("FAIL hs_out_wait_entry: edges=%0d exp 3", n);
        end
        acc = 0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'hABCD) begin
                errs++; $display("FAIL hs_out_stall: valid=%b data=%h exp 1/ABCD", out_valid, out_data);
            end
            step();
        end
        out_ready = 1'b1;
        if (out_valid && out_ready) acc++;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || acc !== 1) begin
            errs++; $display("FAIL hs_out_accept: valid=%b accepts=%0d exp 0/1", out_valid, acc);
        end
        wait_halt(20, n);
        checks++;
        if (halted !== 1'b1 || pc !== 12'h003) begin
            errs++; $display("FAIL hs_halt: halted=%b pc=%h exp 1/003", halted, pc);
        end
    endtask

    task automatic test_reset_store();
        int n;
        begin_test();
        load(12'h010, 16'h1234); load(12'h012, 16'h5555);
        load(12'h000, 16'h1010); load(12'h001, 16'h2012); load(12'h002, 16'h7000);
        release_rst();
        run = 1'b1;
        step();
        run = 1'b0;
        n = 1;
        while (!mem_we && n < 40) begin step(); n++; end
        checks++;
        if (n !== 11 || mem_addr !== 12'h012 || mem_wdata !== 16'h1234) begin
            errs++; $display("FAIL rs_mwrite: edges=%0d addr=%h wdata=%h exp 11/012/1234", n, mem_addr, mem_wdata);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0 || mem_cs !== 1'b0 || pc !== 12'h000 || ac !== 16'h0000) begin
            errs++; $display("FAIL rs_abort: we=%b cs=%b pc=%h ac=%h exp 0/0/000/0000", mem_we, mem_cs, pc, ac);
        end
        step();
        checks++;
        if (mem[12'h012] !== 16'h5555) begin
            errs++; $display("FAIL rs_no_write: mem[012]=%h exp 5555", mem[12'h012]);
        end
        rst = 1'b0;
        step(); step(); step();
        checks++;
        if (mem_cs !== 1'b0 || pc !== 12'h000 || halted !== 1'b0) begin
            errs++; $display("FAIL rs_idle: cs=%b pc=%h halted=%b exp 0/000/0", mem_cs, pc, halted);
        end
        run = 1'b1;
        wait_halt(100, n);
        checks++;
        if (halted !== 1'b1 || mem[12'h012] !== 16'h1234) begin
            errs++; $display("FAIL rs_rerun: halted=%b mem[012]=%h exp 1/1234", halted, mem[12'h012]);
        end
    endtask

    task automatic test_wrap();
        int n;
        logic wrote;
        begin_test();
        load(12'h000, 16'h9FFE); load(12'hFFE, 16'hF123);
        load(12'hFFF, 16'h8400); load(12'h001, 16'h7000);
        release_rst();
        run = 1'b1;
        wrote = 1'b0;
        n = 0;
        while (!(mem_cs && mem_oe && mem_addr == 12'hFFE) && n < 40) begin
            step(); n++;
            if (mem_we) wrote = 1'b1;
        end
        n = 0;
        do begin
            step(); n++;
            if (mem_we) wrote = 1'b1;
        end while (!(mem_cs && mem_oe && mem_addr == 12'hFFF) && n < 40);
        checks++;
        if (n !== 4 || pc !== 12'hFFF) begin
            errs++; $display("FAIL wrap_nop: edges=%0d pc=%h exp 4/FFF", n, pc);
        end
        n = 0;
        while (!halted && n < 40) begin
            step(); n++;
            if (mem_we) wrote = 1'b1;
        end
        checks++;
        if (halted !== 1'b1 || pc !== 12'h002 || ac !== 16'h0000) begin
            errs++; $display("FAIL wrap_skip: halted=%b pc=%h ac=%h exp 1/002/0000", halted, pc, ac);
        end
        checks++;
        if (wrote !== 1'b0) begin
            errs++; $display("FAIL wrap_no_write: we seen=%b exp 0", wrote);
        end
    endtask

    initial begin
        test_reset();
        test_load_add_store();
        test_subt_skip();
        test_loop();
        test_handshake();
        test_reset_store();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
